// File: rtl/gpio_debounce_if.sv
// Pin-side bundle of the debouncer: raw pin levels in, filtered levels and change pulses out.
// master drives the raw pins, slave is the debouncer.
interface gpio_debounce_if #(
    parameter int NIN = 16
);
    logic [NIN-1:0] i_pins;
    logic [NIN-1:0] o_gpio;
    logic [NIN-1:0] o_rise;
    logic [NIN-1:0] o_fall;
    logic           o_any;

    modport master (
        output i_pins,
        input  o_gpio,
        input  o_rise,
        input  o_fall,
        input  o_any
    );

    modport slave (
        input  i_pins,
        output o_gpio,
        output o_rise,
        output o_fall,
        output o_any
    );
endinterface

// File: rtl/gpio_debounce.sv
// Two-flop synchronizer plus per-pin debounce counters on a shared prescaler tick; accepted changes emit registered rise/fall/any pulses.
// Latency with PRESCALE=1: a level captured at edge E0 reaches o_gpio at edge E(NSAMPLES+1); no backpressure.
module gpio_debounce #(
    parameter int             NIN      = 16,
    parameter int             PRESCALE = 100,
    parameter int             NSAMPLES = 4,
    parameter logic [NIN-1:0] DEFAULT  = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    gpio_debounce_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = (NSAMPLES > 1) ? $clog2(NSAMPLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSAMPLES - 1);

    logic [NIN-1:0] s1_q, s2_q;
    logic [NIN-1:0] gpio_q, gpio_d;
    logic [NIN-1:0] rise_q, rise_d;
    logic [NIN-1:0] fall_q, fall_d;
    logic           any_q, any_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic           tick;
    logic [CW-1:0]  cnt_q [NIN];
    logic [CW-1:0]  cnt_d [NIN];

    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // Any sample matching the current filtered level restarts that pin's count,
    // so a bounce always costs the full NSAMPLES ticks again.
    always_comb begin
        gpio_d = gpio_q;
        rise_d = '0;
        fall_d = '0;
        for (int k = 0; k < NIN; k++) begin
            cnt_d[k] = cnt_q[k];
            if (s2_q[k] == gpio_q[k]) begin
                cnt_d[k] = '0;
            end else if (tick && (cnt_q[k] == CNT_LAST)) begin
                gpio_d[k] = s2_q[k];
                rise_d[k] = s2_q[k];
                fall_d[k] = ~s2_q[k];
                cnt_d[k]  = '0;
            end else if (tick) begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_q   <= DEFAULT;
            s2_q   <= DEFAULT;
            gpio_q <= DEFAULT;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
            pre_q  <= '0;
            for (int k = 0; k < NIN; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            s1_q   <= bus.i_pins;
            s2_q   <= s1_q;
            gpio_q <= gpio_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
            pre_q  <= pre_d;
            for (int k = 0; k < NIN; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign bus.o_gpio = gpio_q;
    assign bus.o_rise = rise_q;
    assign bus.o_fall = fall_q;
    assign bus.o_any  = any_q;
endmodule
